rv32i_decode_pipe: RTL and testbench
====================================

Name: rv32i_decode_pipe

Overview:
- Decode/issue stage that feeds the RV32I pipelined ALU.
- Accepts a fetched instruction word and its PC, and reads rs1/rs2 from the register file.
- Produces a registered {operation, operand1, operand2, rd} packet with a single-cycle data_ready pulse.
- Holds a register scoreboard and stalls fetch on read-after-write hazards until writeback retires the producer.

Parameters:
XLEN, 32, datapath width
PC_WIDTH, 32, width of the program counter input

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
clear_i  in  1  pipeline flush; same signal is driven to all stages
data_ready_i  in  1  instruction_i/pc_i valid this cycle
instruction_i  in  32  raw instruction word
pc_i  in  PC_WIDTH  address of instruction_i
stall_o  out  1  upstream must hold instruction_i/pc_i/data_ready_i unchanged while high
rs1_addr_o  out  5  register-file read address 1, instruction_i[19:15]
rs2_addr_o  out  5  register-file read address 2, instruction_i[24:20]
rs1_data_i  in  XLEN  combinational register-file read data 1
rs2_data_i  in  XLEN  combinational register-file read data 2
wb_valid_i  in  1  writeback retiring a register write this cycle
wb_rd_i  in  5  destination being retired
data_ready_o  out  1  decoded packet valid (one cycle per instruction)
operation_o  out  4  ALU opcode: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
operand1_o  out  XLEN  ALU operand 1
operand2_o  out  XLEN  ALU operand 2
rd_o  out  5  destination register
rd_write_o  out  1  packet writes rd (0 for branch/store, or when rd==0)
class_o  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR
store_data_o  out  XLEN  rs2 value for stores
funct3_o  out  3  instruction[14:12], passed through for branch/load/store sizing
illegal_o  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (reset_i): all outputs and registered state go to 0; scoreboard busy[31:1] = 0.
- Priority: reset_i > clear_i > issue.
- clear_i:
  - data_ready_o and illegal_o go to 0 the next cycle.
  - Scoreboard is zeroed; the same cycle's wb_valid_i is ignored.
  - Packet data registers are not required to change.
- Issue condition: data_ready_i & ~stall_o & ~clear_i. Registered outputs update on the next edge. Latency is 1 cycle.
- data_ready_o is high exactly one cycle per issued legal instruction; otherwise 0.
- stall_o is combinational: data_ready_i & ((uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2])).
  - No bypass: a register retiring via wb this cycle still stalls; issue happens the following cycle.
  - busy[0] is hard 0.
- Scoreboard update per edge:
  - Set busy[rd] on issue when rd_write.
  - Clear busy[wb_rd_i] on wb_valid_i.
  - Same register set and cleared in one cycle: set wins.
- Decode by opcode[6:0]:
  - OP (0110011): op = {f7[5], f3}; operands rs1, rs2.
  - OP-IMM (0010011): op = {f3==101 ? f7[5] : 0, f3}; operands rs1, sign-extended I-imm.
  - LUI: ADD, 0, U-imm.
  - AUIPC: ADD, pc (zero-extended), U-imm.
  - LOAD: ADD, rs1, I-imm, rd_write = 1.
  - STORE: ADD, rs1, S-imm, store_data_o = rs2, rd_write = 0.
  - BRANCH: SUB, rs1, rs2, rd_write = 0. The ALU flags drive the branch decision.
  - JAL: ADD, pc, 4 (link value).
  - JALR: ADD, pc, 4 (link value); uses rs1 for the hazard check only.
  - Any other opcode: no issue, illegal_o = 1 for one cycle, scoreboard unchanged.
- uses_rs1 = OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
- uses_rs2 = OP, STORE, BRANCH.
- rd_write_o = writes_rd & (rd != 0).
- Reset or clear asserted while stall_o is high drops the pending instruction; fetch replays it.

Decomposition:
- Shared package rv32i_defs:
  - ALU opcode localparams (OP_ADD..OP_SRA), shared with the ALU stage.
  - RISC-V opcode constants.
  - class_o encodings.
- Sub-module rv32i_scoreboard: busy vector, set/clear/flush, and two hazard-check read ports.
- Immediate generation stays inline.

Test Plan:
- ADDI x5,x0,-3 (0xFFD00293), no hazards -> next cycle data_ready_o=1, op=0000, operand1=0, operand2=0xFFFFFFFD, rd=5, rd_write=1; busy[5]=1.
- Issue ADD x3,x1,x2, then SUB x4,x3,x1 -> stall_o=1 until wb_valid_i with wb_rd_i=3. The issue happens the cycle after wb; op=1000.
- SRAI x6,x7,4 (0x4043D313) -> op=1101, operand2=4. SRLI x6,x7,4 -> op=0101.
- AUIPC x1,0x12345 at pc 0x100 -> op=0000, operand1=0x100, operand2=0x12345000.
- clear_i asserted while busy[3]=1 and data_ready_i=1 -> data_ready_o=0 next cycle, all busy=0, a simultaneous wb ignored.
- Opcode 0x7F -> illegal_o high one cycle, data_ready_o=0. BEQ x1,x2 -> op=1000, rd_write=0, class=3.

Source files
------------

// File: rtl/rv32i_defs.sv
// Shared RV32I definitions: ALU opcodes, base opcodes and instruction classes.
// The ALU stage imports the same opcode encodings.
package rv32i_defs;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ClsAlu    = 3'd0,
        ClsLoad   = 3'd1,
        ClsStore  = 3'd2,
        ClsBranch = 3'd3,
        ClsJal    = 3'd4,
        ClsJalr   = 3'd5
    } iclass_e;

endpackage

// File: rtl/rv32i_scoreboard.sv
// Register busy vector with set/clear/flush and two hazard-check read ports.
// x0 is never busy.
module rv32i_scoreboard
    import rv32i_defs::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       flush_i,
    input  logic       set_i,
    input  logic [4:0] set_addr_i,
    input  logic       clr_i,
    input  logic [4:0] clr_addr_i,
    input  logic [4:0] rd_addr_a_i,
    input  logic [4:0] rd_addr_b_i,
    output logic       busy_a_o,
    output logic       busy_b_o
);

    logic [31:0] busy_q, busy_d;

    // Set after clear so a same-cycle set/clear of one register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (clr_i) busy_d[clr_addr_i] = 1'b0;
            if (set_i) busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_a_o = busy_q[rd_addr_a_i];
    assign busy_b_o = busy_q[rd_addr_b_i];

endmodule

// File: rtl/rv32i_decode_pipe.sv
// RV32I decode/issue stage: decodes one instruction per cycle into a registered ALU packet
// and stalls fetch on read-after-write hazards tracked by the scoreboard.
module rv32i_decode_pipe
    import rv32i_defs::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                data_ready_i,
    input  logic [31:0]         instruction_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic                stall_o,
    output logic [4:0]          rs1_addr_o,
    output logic [4:0]          rs2_addr_o,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic                wb_valid_i,
    input  logic [4:0]          wb_rd_i,
    output logic                data_ready_o,
    output logic [3:0]          operation_o,
    output logic [XLEN-1:0]     operand1_o,
    output logic [XLEN-1:0]     operand2_o,
    output logic [4:0]          rd_o,
    output logic                rd_write_o,
    output logic [2:0]          class_o,
    output logic [XLEN-1:0]     store_data_o,
    output logic [2:0]          funct3_o,
    output logic                illegal_o
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            f7b5;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_u;

    assign opcode     = instruction_i[6:0];
    assign rd         = instruction_i[11:7];
    assign f3         = instruction_i[14:12];
    assign f7b5       = instruction_i[30];
    assign rs1_addr_o = instruction_i[19:15];
    assign rs2_addr_o = instruction_i[24:20];

    assign imm_i = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_u = {{(XLEN-32){instruction_i[31]}}, instruction_i[31:12], 12'b0};

    logic            legal, uses_rs1, uses_rs2, writes_rd;
    logic [3:0]      op;
    logic [XLEN-1:0] opnd1, opnd2;
    iclass_e         cls;

    always_comb begin
        legal     = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b1;
        op        = OP_ADD;
        opnd1     = '0;
        opnd2     = '0;
        cls       = ClsAlu;
        unique case (opcode)
            OPC_OP: begin
                op = {f7b5, f3};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                opnd1 = rs1_data_i;
                opnd2 = rs2_data_i;
            end
            OPC_OP_IMM: begin
                // Only the shift-right encoding carries an opcode bit in funct7.
                op = {(f3 == 3'b101) & f7b5, f3};
                uses_rs1 = 1'b1;
                opnd1 = rs1_data_i;
                opnd2 = imm_i;
            end
            OPC_LUI: opnd2 = imm_u;
            OPC_AUIPC: begin
                opnd1 = XLEN'(pc_i);
                opnd2 = imm_u;
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                opnd1 = rs1_data_i;
                opnd2 = imm_i;
                cls = ClsLoad;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                writes_rd = 1'b0;
                opnd1 = rs1_data_i;
                opnd2 = imm_s;
                cls = ClsStore;
            end
            OPC_BRANCH: begin
                op = OP_SUB;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                writes_rd = 1'b0;
                opnd1 = rs1_data_i;
                opnd2 = rs2_data_i;
                cls = ClsBranch;
            end
            OPC_JAL: begin
                opnd1 = XLEN'(pc_i);
                opnd2 = XLEN'(4);
                cls = ClsJal;
            end
            OPC_JALR: begin
                // rs1 only gates the hazard check; the target adder lives elsewhere.
                uses_rs1 = 1'b1;
                opnd1 = XLEN'(pc_i);
                opnd2 = XLEN'(4);
                cls = ClsJalr;
            end
            default: begin
                legal = 1'b0;
                writes_rd = 1'b0;
            end
        endcase
    end

    logic busy_rs1, busy_rs2, issue, rd_write;

    assign stall_o  = data_ready_i & ((uses_rs1 & busy_rs1) | (uses_rs2 & busy_rs2));
    assign issue    = data_ready_i & ~stall_o & ~clear_i;
    assign rd_write = writes_rd & (rd != 5'd0);

    rv32i_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (clear_i),
        .set_i       (issue & legal & rd_write),
        .set_addr_i  (rd),
        .clr_i       (wb_valid_i),
        .clr_addr_i  (wb_rd_i),
        .rd_addr_a_i (rs1_addr_o),
        .rd_addr_b_i (rs2_addr_o),
        .busy_a_o    (busy_rs1),
        .busy_b_o    (busy_rs2)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_ready_o <= 1'b0;
            illegal_o    <= 1'b0;
            operation_o  <= '0;
            operand1_o   <= '0;
            operand2_o   <= '0;
            rd_o         <= '0;
            rd_write_o   <= 1'b0;
            class_o      <= '0;
            store_data_o <= '0;
            funct3_o     <= '0;
        end else begin
            data_ready_o <= issue & legal;
            illegal_o    <= issue & ~legal;
            if (issue & legal) begin
                operation_o  <= op;
                operand1_o   <= opnd1;
                operand2_o   <= opnd2;
                rd_o         <= rd;
                rd_write_o   <= rd_write;
                class_o      <= cls;
                store_data_o <= rs2_data_i;
                funct3_o     <= f3;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_decode_pipe.sv
// Randomized bench for rv32i_decode_pipe against a behavioural decode/scoreboard model,
// seeded with a short list of hand-picked instructions.
module tb_rv32i_decode_pipe;

    logic        clk_i = 1'b0;
    logic        reset_i, clear_i, data_ready_i, wb_valid_i;
    logic [31:0] instruction_i, pc_i, rs1_data_i, rs2_data_i;
    logic [4:0]  wb_rd_i;
    logic        stall_o, data_ready_o, rd_write_o, illegal_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_o;
    logic [3:0]  operation_o;
    logic [31:0] operand1_o, operand2_o, store_data_o;
    logic [2:0]  class_o, funct3_o;

    always #5 clk_i = ~clk_i;

    rv32i_decode_pipe #(.XLEN(32), .PC_WIDTH(32)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .data_ready_i  (data_ready_i),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .stall_o       (stall_o),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .data_ready_o  (data_ready_o),
        .operation_o   (operation_o),
        .operand1_o    (operand1_o),
        .operand2_o    (operand2_o),
        .rd_o          (rd_o),
        .rd_write_o    (rd_write_o),
        .class_o       (class_o),
        .store_data_o  (store_data_o),
        .funct3_o      (funct3_o),
        .illegal_o     (illegal_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the ISA tables.
    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] r1, input logic [31:0] r2,
                              output bit legal, output bit u1, output bit u2, output bit wr,
                              output logic [3:0] op, output logic [31:0] a,
                              output logic [31:0] b, output logic [2:0] cls);
        int imm_i, imm_s, f3;
        imm_i = $signed(ins) >>> 20;
        imm_s = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
        f3    = int'(ins[14:12]);
        legal = 1; u1 = 0; u2 = 0; wr = 1; op = 4'd0; a = 0; b = 0; cls = 3'd0;
        case (ins[6:0])
            7'b0110011: begin op = 4'(int'(ins[30]) * 8 + f3); u1 = 1; u2 = 1; a = r1; b = r2; end
            7'b0010011: begin
                op = 4'((f3 == 5 ? int'(ins[30]) : 0) * 8 + f3);
                u1 = 1; a = r1; b = imm_i;
            end
            7'b0110111: b = ins & 32'hFFFF_F000;
            7'b0010111: begin a = pc; b = ins & 32'hFFFF_F000; end
            7'b0000011: begin u1 = 1; a = r1; b = imm_i; cls = 3'd1; end
            7'b0100011: begin u1 = 1; u2 = 1; wr = 0; a = r1; b = imm_s; cls = 3'd2; end
            7'b1100011: begin op = 4'b1000; u1 = 1; u2 = 1; wr = 0; a = r1; b = r2; cls = 3'd3; end
            7'b1101111: begin a = pc; b = 4; cls = 3'd4; end
            7'b1100111: begin u1 = 1; a = pc; b = 4; cls = 3'd5; end
            default: begin legal = 0; wr = 0; end
        endcase
    endtask

    function automatic bit is_legal_opc(input logic [6:0] o);
        return o inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                         7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
    endfunction

    logic [31:0] dir_ins [8] = '{32'hFFD00293, 32'h002081B3, 32'h40118233, 32'h4043D313,
                                 32'h0043D313, 32'h12345097, 32'h0000007F, 32'h00208063};
    logic [6:0]  opc_pool [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                                  7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};

    initial begin
        bit          busy [32];
        logic [4:0]  inflight [$];
        bit          hold, have_exp, chk_all, rst, dr, clr, wb, issue, exp_stall;
        bit          legal, u1, u2, wr, rdw_now;
        logic [3:0]  op;
        logic [31:0] a, b, ins, pc, r1, r2;
        logic [2:0]  cls;
        logic [4:0]  wbrd;
        logic [6:0]  opc;
        int          dix;
        bit          e_dr, e_ill, e_rdw;
        logic [3:0]  e_op;
        logic [31:0] e_o1, e_o2, e_sd;
        logic [4:0]  e_rd;
        logic [2:0]  e_cls, e_f3;

        foreach (busy[i]) busy[i] = 0;
        hold = 0; have_exp = 0; chk_all = 0; dix = 0; ins = 0; pc = 0; dr = 0;
        e_dr = 0; e_ill = 0; e_rdw = 0; e_op = 0; e_o1 = 0; e_o2 = 0; e_sd = 0;
        e_rd = 0; e_cls = 0; e_f3 = 0;
        reset_i = 1; clear_i = 0; data_ready_i = 0; instruction_i = 0; pc_i = 0;
        rs1_data_i = 0; rs2_data_i = 0; wb_valid_i = 0; wb_rd_i = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            if (have_exp) begin
                check("data_ready_o", 32'(data_ready_o), 32'(e_dr));
                check("illegal_o", 32'(illegal_o), 32'(e_ill));
                if (e_dr || chk_all) begin
                    check("operation_o", 32'(operation_o), 32'(e_op));
                    check("operand1_o", operand1_o, e_o1);
                    check("operand2_o", operand2_o, e_o2);
                    check("rd_o", 32'(rd_o), 32'(e_rd));
                    check("rd_write_o", 32'(rd_write_o), 32'(e_rdw));
                    check("class_o", 32'(class_o), 32'(e_cls));
                    check("funct3_o", 32'(funct3_o), 32'(e_f3));
                    if (e_cls == 3'd2 || chk_all) check("store_data_o", store_data_o, e_sd);
                end
            end

            rst = (cyc < 2) || (cyc == 1500);
            if (rst) begin
                dr = 0;
            end else if (!hold) begin
                if (dix < 8) begin
                    ins = dir_ins[dix];
                    pc = (dix == 5) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
                    dix++;
                    dr = 1;
                end else begin
                    ins = $urandom;
                    if ($urandom_range(0, 9) == 0) begin
                        do opc = 7'($urandom); while (is_legal_opc(opc));
                    end else begin
                        opc = opc_pool[$urandom_range(0, 8)];
                    end
                    ins[6:0]   = opc;
                    ins[11:7]  = 5'($urandom_range(0, 7));
                    ins[19:15] = 5'($urandom_range(0, 7));
                    ins[24:20] = 5'($urandom_range(0, 7));
                    pc = $urandom & 32'hFFFF_FFFC;
                    dr = ($urandom_range(0, 9) < 8);
                end
            end

            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb = 1; wbrd = inflight.pop_front();
            end else begin
                wb = ($urandom_range(0, 15) == 0); wbrd = 5'($urandom_range(0, 7));
            end
            clr = !rst && cyc > 40 && ($urandom_range(0, 29) == 0);
            r1 = $urandom; r2 = $urandom;

            reset_i = rst; clear_i = clr; data_ready_i = dr; instruction_i = ins; pc_i = pc;
            rs1_data_i = r1; rs2_data_i = r2; wb_valid_i = wb; wb_rd_i = wbrd;
            #1;

            ref_decode(ins, pc, r1, r2, legal, u1, u2, wr, op, a, b, cls);
            exp_stall = dr && ((u1 && ins[19:15] != 0 && busy[ins[19:15]]) ||
                               (u2 && ins[24:20] != 0 && busy[ins[24:20]]));
            check("stall_o", 32'(stall_o), 32'(exp_stall));
            check("rs1_addr_o", 32'(rs1_addr_o), 32'(ins[19:15]));
            check("rs2_addr_o", 32'(rs2_addr_o), 32'(ins[24:20]));

            issue = dr && !exp_stall && !clr && !rst;
            rdw_now = wr && (ins[11:7] != 0);
            if (rst) begin
                e_dr = 0; e_ill = 0; e_rdw = 0; e_op = 0; e_o1 = 0; e_o2 = 0; e_sd = 0;
                e_rd = 0; e_cls = 0; e_f3 = 0;
                foreach (busy[i]) busy[i] = 0;
                inflight.delete();
            end else begin
                e_dr = issue && legal;
                e_ill = issue && !legal;
                if (issue && legal) begin
                    e_op = op; e_o1 = a; e_o2 = b; e_rd = ins[11:7]; e_rdw = rdw_now;
                    e_cls = cls; e_f3 = ins[14:12]; e_sd = r2;
                end
                if (clr) begin
                    foreach (busy[i]) busy[i] = 0;
                    inflight.delete();
                end else begin
                    if (wb) busy[wbrd] = 0;
                    if (issue && legal && rdw_now) begin
                        busy[ins[11:7]] = 1;
                        inflight.push_back(ins[11:7]);
                    end
                end
            end
            hold = dr && exp_stall && !clr && !rst;
            have_exp = 1;
            chk_all = rst;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
